// File: rtl/key_extractor_if.sv
// key_extractor_if: PHV input, key/PHV output and config-write bundle for key_extractor
interface key_extractor_if #(
    parameter int PHV_LEN = 1124,
    parameter int KEY_LEN = 197
);
    logic [PHV_LEN-1:0] phv_in;
    logic               phv_valid;
    logic               phv_ready;
    logic [KEY_LEN-1:0] extract_key;
    logic               key_valid;
    logic [PHV_LEN-1:0] phv_out;
    logic [22:0]        key_cfg_din;
    logic [3:0]         key_cfg_addr;
    logic               key_cfg_en;
    logic [KEY_LEN-1:0] key_mask_din;

    modport master (
        output phv_in, phv_valid, key_cfg_din, key_cfg_addr, key_cfg_en, key_mask_din,
        input  phv_ready, extract_key, key_valid, phv_out
    );

    modport slave (
        input  phv_in, phv_valid, key_cfg_din, key_cfg_addr, key_cfg_en, key_mask_din,
        output phv_ready, extract_key, key_valid, phv_out
    );
endinterface

// File: rtl/key_extractor.sv
// key_extractor: builds a lookup key from PHV containers chosen by a per-vid config table; optional key mask table under KEY_EXTRACT_MASK_EN
module key_extractor #(
    parameter int STAGE   = 0,
    parameter int PHV_LEN = 1124,
    parameter int KEY_LEN = 197,
    parameter int KEY_GAP = 4
) (
    input logic            clk,
    input logic            rst,
    key_extractor_if.slave bus
);
    localparam int unused_stage = STAGE;

    logic               accept, push, pop;
    logic [3:0]         vid;
    logic               s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [PHV_LEN-1:0] s1_phv_q, s1_phv_d, s2_phv_q, s2_phv_d;
    logic [22:0]        s1_cfg_q, s1_cfg_d;
    logic [KEY_LEN-1:0] s2_key_q, s2_key_d, key_raw, key_final;
    logic [22:0]        cfg_q [16];
    logic [22:0]        cfg_d [16];
    logic [KEY_LEN-1:0] fifo_key_q [4];
    logic [KEY_LEN-1:0] fifo_key_d [4];
    logic [PHV_LEN-1:0] fifo_phv_q [4];
    logic [PHV_LEN-1:0] fifo_phv_d [4];
    logic [1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]         count_q, count_d;
    logic [3:0]         gap_q, gap_d;
    logic               key_valid_q, key_valid_d;
    logic [KEY_LEN-1:0] extract_key_q, extract_key_d;
    logic [PHV_LEN-1:0] phv_out_q, phv_out_d;
    logic [47:0]        c48 [8];
    logic [31:0]        c32 [8];
    logic [15:0]        c16 [8];

    assign vid    = bus.phv_in[255:252];
    assign accept = bus.phv_valid && bus.phv_ready;
    assign push   = s2_valid_q;
    assign pop    = (count_q != 3'd0) && (gap_q == 4'd0);

    // Occupancy counts every PHV already committed to the pipe, so the FIFO can never overflow
    assign bus.phv_ready   = !rst && ((4'(count_q) + 4'(s1_valid_q) + 4'(s2_valid_q)) < 4'd4);
    assign bus.key_valid   = key_valid_q;
    assign bus.extract_key = extract_key_q;
    assign bus.phv_out     = phv_out_q;

    // Slice the S1 PHV into containers and assemble the selected fields into the raw key
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            c48[i] = s1_phv_q[PHV_LEN-1-48*i -: 48];
            c32[i] = s1_phv_q[PHV_LEN-385-32*i -: 32];
            c16[i] = s1_phv_q[PHV_LEN-641-16*i -: 16];
        end
        key_raw = {c48[s1_cfg_q[22:20]], c48[s1_cfg_q[19:17]], c32[s1_cfg_q[16:14]],
                   c32[s1_cfg_q[13:11]], c16[s1_cfg_q[10:8]], c16[s1_cfg_q[7:5]], s1_cfg_q[4:0]};
    end

`ifdef KEY_EXTRACT_MASK_EN
    logic [KEY_LEN-1:0] mask_q [16];
    logic [KEY_LEN-1:0] mask_d [16];
    logic [KEY_LEN-1:0] s1_mask_q, s1_mask_d;

    assign key_final = key_raw & s1_mask_q;

    // Mask table written alongside the config table; read with the same read-first timing
    always_comb begin
        mask_d = mask_q;
        if (bus.key_cfg_en) mask_d[bus.key_cfg_addr] = bus.key_mask_din;
        s1_mask_d = accept ? mask_q[vid] : s1_mask_q;
    end

    // Mask state; an unwritten mask passes the key through
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q    <= '{default: '1};
            s1_mask_q <= '1;
        end else begin
            mask_q    <= mask_d;
            s1_mask_q <= s1_mask_d;
        end
    end
`else
    logic unused_mask;

    assign unused_mask = ^bus.key_mask_din;
    assign key_final   = key_raw;
`endif

    // Next state for config table, S1/S2 pipe, FIFO, gap counter and output registers
    always_comb begin
        cfg_d = cfg_q;
        if (bus.key_cfg_en) cfg_d[bus.key_cfg_addr] = bus.key_cfg_din;
        s1_valid_d = accept;
        s1_phv_d   = accept ? bus.phv_in : s1_phv_q;
        s1_cfg_d   = accept ? cfg_q[vid] : s1_cfg_q;
        s2_valid_d = s1_valid_q;
        s2_key_d   = s1_valid_q ? key_final : s2_key_q;
        s2_phv_d   = s1_valid_q ? s1_phv_q : s2_phv_q;
        fifo_key_d = fifo_key_q;
        fifo_phv_d = fifo_phv_q;
        if (push) begin
            fifo_key_d[wr_ptr_q] = s2_key_q;
            fifo_phv_d[wr_ptr_q] = s2_phv_q;
        end
        wr_ptr_d      = wr_ptr_q + 2'(push);
        rd_ptr_d      = rd_ptr_q + 2'(pop);
        count_d       = count_q + 3'(push) - 3'(pop);
        gap_d         = pop ? 4'(KEY_GAP - 1) : (gap_q != 4'd0 ? gap_q - 4'd1 : 4'd0);
        key_valid_d   = pop;
        extract_key_d = pop ? fifo_key_q[rd_ptr_q] : extract_key_q;
        phv_out_d     = pop ? fifo_phv_q[rd_ptr_q] : phv_out_q;
    end

    // State registers with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q         <= '{default: '0};
            s1_valid_q    <= 1'b0;
            s1_phv_q      <= '0;
            s1_cfg_q      <= '0;
            s2_valid_q    <= 1'b0;
            s2_key_q      <= '0;
            s2_phv_q      <= '0;
            fifo_key_q    <= '{default: '0};
            fifo_phv_q    <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            gap_q         <= '0;
            key_valid_q   <= 1'b0;
            extract_key_q <= '0;
            phv_out_q     <= '0;
        end else begin
            cfg_q         <= cfg_d;
            s1_valid_q    <= s1_valid_d;
            s1_phv_q      <= s1_phv_d;
            s1_cfg_q      <= s1_cfg_d;
            s2_valid_q    <= s2_valid_d;
            s2_key_q      <= s2_key_d;
            s2_phv_q      <= s2_phv_d;
            fifo_key_q    <= fifo_key_d;
            fifo_phv_q    <= fifo_phv_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            gap_q         <= gap_d;
            key_valid_q   <= key_valid_d;
            extract_key_q <= extract_key_d;
            phv_out_q     <= phv_out_d;
        end
    end
endmodule

// File: tb/tb_key_extractor.sv
// tb_key_extractor: directed checks of key_extractor latency, pacing, config timing, reset and masking
module tb_key_extractor;
    localparam int PL = 1124;
    localparam int KL = 197;

    typedef struct {
        logic [KL-1:0] key;
        logic [PL-1:0] phv;
        int            acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    key_extractor_if #(.PHV_LEN(PL), .KEY_LEN(KL)) ifc ();

    key_extractor #(.STAGE(0), .PHV_LEN(PL), .KEY_LEN(KL), .KEY_GAP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            pulses = 0;
    int            last_pulse = -1;
    bit            lat_chk = 0;
    bit            gap_chk = 0;
    bit            nr_seen = 0;
    exp_t          q[$];
    logic [22:0]   cfg_m [16];
    logic [KL-1:0] mask_m [16];
    logic [KL-1:0] last_key;
    logic [KL-1:0] all_ones = '1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PL-1:0] make_phv(input logic [15:0] seed, input logic [3:0] vid);
        logic [1151:0] t;
        logic [PL-1:0] p;
        for (int w = 0; w < 36; w++) t[32*w +: 32] = {seed, 16'(w * 257) ^ 16'h5a5a};
        p = t[PL-1:0];
        p[255:252] = vid;
        return p;
    endfunction

    function automatic logic [KL-1:0] model_key(input logic [PL-1:0] p, input logic [22:0] c);
        int a, b, d, e, f, g;
        a = int'(c[22:20]); b = int'(c[19:17]); d = int'(c[16:14]);
        e = int'(c[13:11]); f = int'(c[10:8]);  g = int'(c[7:5]);
        return {p[PL-1-48*a -: 48], p[PL-1-48*b -: 48], p[PL-385-32*d -: 32],
                p[PL-385-32*e -: 32], p[PL-641-16*f -: 16], p[PL-641-16*g -: 16], c[4:0]};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (ifc.key_valid === 1'b1) begin
            pulses++;
            if (q.size() == 0) check("spurious_kv", 1, 0);
            else begin
                e = q.pop_front();
                check("key", ifc.extract_key, e.key);
                check("phv_out", ifc.phv_out == e.phv, 1);
                if (lat_chk) check("latency", cyc - e.acc, 3);
                if (gap_chk && last_pulse >= 0) check("gap", cyc - last_pulse, 4);
                last_key = e.key;
            end
            last_pulse = cyc;
        end
    end

    task automatic drive(input logic [PL-1:0] p, input bit v, input bit we, input logic [3:0] wa,
                         input logic [22:0] wd, input logic [KL-1:0] wm, output bit acc);
        exp_t e;
        @(negedge clk);
        ifc.phv_in       = p;
        ifc.phv_valid    = v;
        ifc.key_cfg_en   = we;
        ifc.key_cfg_addr = wa;
        ifc.key_cfg_din  = wd;
        ifc.key_mask_din = wm;
        acc = v && ifc.phv_ready;
        if (v && !ifc.phv_ready) nr_seen = 1;
        if (acc) begin
`ifdef KEY_EXTRACT_MASK_EN
            e.key = model_key(p, cfg_m[p[255:252]]) & mask_m[p[255:252]];
`else
            e.key = model_key(p, cfg_m[p[255:252]]);
`endif
            e.phv = p;
            e.acc = cyc + 1;
            q.push_back(e);
        end
        if (we) begin
            cfg_m[wa]  = wd;
            mask_m[wa] = wm;
        end
        @(posedge clk);
        #1;
        ifc.phv_valid  = 1'b0;
        ifc.key_cfg_en = 1'b0;
    endtask

    task automatic send(input logic [PL-1:0] p, input bit we, input logic [3:0] wa,
                        input logic [22:0] wd, input logic [KL-1:0] wm);
        bit acc;
        int n = 0;
        drive(p, 1, we, wa, wd, wm, acc);
        while (!acc && n < 40) begin
            drive(p, 1, 0, 4'd0, 23'd0, all_ones, acc);
            n++;
        end
        check("accepted", acc, 1);
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) drive('0, 0, 0, 4'd0, 23'd0, all_ones, a);
    endtask

    task automatic wcfg(input logic [3:0] wa, input logic [22:0] wd, input logic [KL-1:0] wm);
        bit a;
        drive('0, 0, 1, wa, wd, wm, a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        for (int i = 0; i < 16; i++) begin
            cfg_m[i]  = '0;
            mask_m[i] = '1;
        end
        @(negedge clk);
        check("ready_in_rst", ifc.phv_ready, 0);
        check("kv_in_rst", ifc.key_valid, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", ifc.phv_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PL-1:0] p1;
        logic [KL-1:0] m2;
        int p0;
        ifc.phv_in = '0;
        ifc.phv_valid = 1'b0;
        ifc.key_cfg_en = 1'b0;
        ifc.key_cfg_addr = '0;
        ifc.key_cfg_din = '0;
        ifc.key_mask_din = '1;
        for (int i = 0; i < 16; i++) begin
            cfg_m[i]  = '0;
            mask_m[i] = '1;
        end
        repeat (2) @(negedge clk);
        check("rst_kv", ifc.key_valid, 0);
        check("rst_key", ifc.extract_key, 0);
        check("rst_phv_out", ifc.phv_out == '0, 1);
        check("rst_ready", ifc.phv_ready, 0);
        rst = 1'b0;
        #1;
        check("ready_post_rst", ifc.phv_ready, 1);

        // single PHV, vid 0, empty pipe
        wcfg(4'd0, {3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 5'h1F}, all_ones);
        p1 = make_phv(16'h1111, 4'd0);
        lat_chk = 1;
        send(p1, 0, 4'd0, 23'd0, all_ones);
        idle(8);
        check("t1_flags", ifc.extract_key[4:0], 5'h1F);
        check("t1_c48_0", ifc.extract_key[196:149], p1[1123:1076]);
        check("t1_c16_1", ifc.extract_key[20:5], p1[467:452]);
        check("hold_key", ifc.extract_key, last_key);
        check("hold_phv", ifc.phv_out == p1, 1);
        lat_chk = 0;

        // six back-to-back PHVs, paced by the gap counter
        wcfg(4'd1, {3'd2, 3'd7, 3'd3, 3'd6, 3'd4, 3'd5, 5'h0A}, all_ones);
        gap_chk = 1;
        last_pulse = -1;
        nr_seen = 0;
        p0 = pulses;
        for (int i = 0; i < 6; i++) send(make_phv(16'h2000 + 16'(i), 4'd1), 0, 4'd0, 23'd0, all_ones);
        idle(30);
        check("ready_dropped", nr_seen, 1);
        check("t2_pulses", pulses - p0, 6);
        gap_chk = 0;

        // config write colliding with a vid-3 accept
        lat_chk = 1;
        wcfg(4'd3, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 5'h03}, all_ones);
        send(make_phv(16'h3001, 4'd3), 1, 4'd3, {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 5'h1C}, all_ones);
        idle(6);
        check("t3_old_flags", ifc.extract_key[4:0], 5'h03);
        send(make_phv(16'h3002, 4'd3), 0, 4'd0, 23'd0, all_ones);
        idle(6);
        check("t3_new_flags", ifc.extract_key[4:0], 5'h1C);

        // mask entry 2 clears the flag bits when masking is built in
        m2 = ~(KL'(5'h1F));
        wcfg(4'd2, {3'd3, 3'd4, 3'd1, 3'd2, 3'd6, 3'd7, 5'h15}, m2);
        send(make_phv(16'h5005, 4'd2), 0, 4'd0, 23'd0, all_ones);
        idle(6);
`ifdef KEY_EXTRACT_MASK_EN
        check("t5_flags", ifc.extract_key[4:0], 5'h00);
`else
        check("t5_flags", ifc.extract_key[4:0], 5'h15);
`endif
        lat_chk = 0;

        // reset with three PHVs in flight
        wcfg(4'd4, {3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 5'h07}, all_ones);
        for (int i = 0; i < 3; i++) send(make_phv(16'h4000 + 16'(i), 4'd4), 0, 4'd0, 23'd0, all_ones);
        do_reset();
        p0 = pulses;
        idle(12);
        check("no_kv_after_rst", pulses, p0);
        check("drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_extractor.md
KEY_EXTRACTOR -- requirements
Module: key_extractor

Interface
REQ-001 SHALL have parameter STAGE, default 0, pipeline stage index (informational; no functional effect).
REQ-002 SHALL have parameter PHV_LEN, default 1124, PHV width (8x48b, 8x32b, 8x16b containers, 100b ext, 256b metadata).
REQ-003 SHALL have parameter KEY_LEN, default 197, key width (2x48b + 2x32b + 2x16b + 5b flags).
REQ-004 SHALL have parameter KEY_GAP, default 4, minimum cycles between key_valid pulses; legal range 1-15.
REQ-005 SHALL have ports:
- clk, in, 1, sole clock; one clock, all logic on its rising edge.
- rst, in, 1, reset; synchronous, active-high.
- phv_in, in, PHV_LEN, incoming PHV.
- phv_valid, in, 1, phv_in valid.
- phv_ready, out, 1, block accepts PHV this cycle.
- extract_key, out, KEY_LEN, key to the lookup stage.
- key_valid, out, 1, one-cycle pulse qualifying extract_key and phv_out.
- phv_out, out, PHV_LEN, PHV paired with extract_key.
- key_cfg_din, in, 23, config entry {sel48a[2:0], sel48b, sel32a, sel32b, sel16a, sel16b, flags[4:0]}.
- key_cfg_addr, in, 4, config entry index.
- key_cfg_en, in, 1, config write strobe.
- key_mask_din, in, KEY_LEN, key mask entry (used only with KEY_EXTRACT_MASK_EN).

Function
REQ-006 SHALL accept a PHV when phv_valid and phv_ready are both high; phv_in is otherwise ignored.
REQ-007 SHALL locate 48b container i at phv[PHV_LEN-1-48i -: 48], 32b container i at phv[PHV_LEN-385-32i -: 32], 16b container i at phv[PHV_LEN-641-16i -: 16], i = 0..7.
REQ-008 SHALL take vid = phv[255:252] and use it to index a 16-entry config table.
REQ-009 SHALL implement stage S1: on accept, register the PHV and read config[vid] (read-first: a same-cycle write to the same address yields the old entry).
REQ-010 SHALL implement stage S2: form key = {c48[sel48a], c48[sel48b], c32[sel32a], c32[sel32b], c16[sel16a], c16[sel16b], flags} and register it with the PHV.
REQ-011 SHALL push each S2 result into a 4-entry FIFO of {key, phv}.
REQ-012 SHALL pop the FIFO when it is non-empty and the gap counter is 0; a pop registers extract_key and phv_out and asserts key_valid for exactly one cycle.
REQ-013 SHALL load the gap counter with KEY_GAP-1 on each pop and decrement it to 0 every cycle thereafter.
REQ-014 SHALL drive phv_ready = (FIFO count + valid S1/S2 entries) < 4; the FIFO never overflows.
REQ-015 SHALL give 3-cycle latency (phv accepted at edge T -> key_valid high after edge T+3) when the pipe is empty and the gap counter is 0.
REQ-016 SHALL sustain back-to-back acceptance while phv_ready is high; order is preserved.
REQ-017 SHALL let a FIFO push and pop in the same cycle leave the count unchanged, including when the FIFO is full.
REQ-018 SHALL hold extract_key and phv_out stable between pops.
REQ-019 SHALL let a config write land in the same cycle as traffic; it affects only PHVs entering S1 on later cycles.

Reset
REQ-020 SHALL, on rst high at a clock edge, clear: key_valid to 0; extract_key and phv_out to 0; FIFO count, S1/S2 valids and gap counter to 0; all config entries to 0.
REQ-021 SHALL, on reset mid-operation, drop all in-flight PHVs with no further key_valid, and SHALL hold phv_ready at 0 while rst is high.
REQ-022 SHALL drive phv_ready to 1 in the first cycle after rst deasserts.

Configuration
REQ-023 SHALL support macro KEY_EXTRACT_MASK_EN: when defined, a 16-entry mask table is written with key_mask_din on key_cfg_en/key_cfg_addr and S2 outputs key & mask[vid]; masks reset to all-ones.
REQ-024 SHALL, when KEY_EXTRACT_MASK_EN is undefined, implement no mask table, ignore key_mask_din, and output the unmasked key.

Verification
REQ-025 SHALL pass: write cfg[0] = sels {0,1,0,1,0,1}, flags 5'h1F; send one PHV with vid 0 -> key_valid exactly 3 cycles later, key = {c48[0], c48[1], c32[0], c32[1], c16[0], c16[1], 5'h1F}, phv_out = phv_in.
REQ-026 SHALL pass: 6 back-to-back PHVs, KEY_GAP = 4 -> key_valid pulses exactly 4 cycles apart, in order; phv_ready drops to 0 once 4 entries are held.
REQ-027 SHALL pass: cfg write to address 3 in the same cycle a vid-3 PHV is accepted -> that key uses the old entry; the next vid-3 PHV uses the new entry.
REQ-028 SHALL pass: rst pulsed with 3 PHVs in flight -> no key_valid afterwards; phv_ready = 1 in the first cycle after rst deasserts.
REQ-029 SHALL pass, with KEY_EXTRACT_MASK_EN defined: mask[2] = low 5 bits cleared -> a vid-2 key has flags 0; without the macro, the flags appear unmasked.
